// File: rtl/mc_rd_pkg.sv
// mc_rd_pkg: shared definitions for the MIG read-command controller.
//   ADDR_W       - MIG byte-address width (30)
//   DATA_W       - MIG read data width (32)
//   MIG_CMD_READ - MIG instruction code for a read command
//   state_t      - controller FSM state encoding
package mc_rd_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic [2:0] MIG_CMD_READ = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_READ      = 3'd3,
        ST_ADVANCE   = 3'd4
    } state_t;

endpackage

// File: rtl/mc_rd_ctrl_if.sv
// mc_rd_ctrl_if: address-source and MIG command/read-FIFO bundle.
//   addr_in        - read address word from the address source ([29:0] byte addr)
//   mc_rd_rdy      - one-cycle pulse: address source advances to next entry
//   cmd_en/instr/bl/byte_addr, cmd_full - MIG command port
//   rd_en, rd_data, rd_empty            - MIG read FIFO (first-word-fall-through)
//   data_out, data_valid                - registered read word and its strobe
// Modports: master = controller side, slave = address source / MIG / sink side.
interface mc_rd_ctrl_if;
    import mc_rd_pkg::*;

    logic [30:0]       addr_in;
    logic              mc_rd_rdy;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic              cmd_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_empty;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;

    modport master (
        input  addr_in, cmd_full, rd_data, rd_empty,
        output mc_rd_rdy, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
               rd_en, data_out, data_valid
    );

    modport slave (
        output addr_in, cmd_full, rd_data, rd_empty,
        input  mc_rd_rdy, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
               rd_en, data_out, data_valid
    );

endinterface

// File: rtl/mc_rd_wdt.sv
// mc_rd_wdt: cycle-count watchdog for the WAIT_DATA state.
//   clk, rst - clock, synchronous active-high reset
//   clear    - restart the count from zero
//   cnt_en   - count this cycle
//   expired  - high on the LIMIT-th consecutive enabled cycle
module mc_rd_wdt #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam int               CNT_W = $clog2(LIMIT) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt_en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = cnt_en && (cnt == LAST);

endmodule

// File: rtl/mc_rd_ctrl.sv
// mc_rd_ctrl: issues one MIG read command per address-source entry, drains
// BURST_LEN words from the read FIFO and then pulses mc_rd_rdy.
//   clk, rst    - clock, synchronous active-high reset
//   run         - level enable for starting new commands
//   calib_done  - MIG calibration complete
//   busy        - high whenever the FSM is not in IDLE
//   rd_timeout  - sticky WAIT_DATA watchdog error (0 unless MC_RD_TIMEOUT_EN)
//   bus         - mc_rd_ctrl_if.master (address source, MIG cmd/read ports)
// Build option: define MC_RD_TIMEOUT_EN to add the WAIT_DATA watchdog
// (mc_rd_wdt, limit TIMEOUT_CYCLES); a timeout returns to IDLE without
// mc_rd_rdy and reissues the same latched address.
module mc_rd_ctrl
    import mc_rd_pkg::*;
#(
    parameter int BURST_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         calib_done,
    output logic         busy,
    output logic         rd_timeout,
    mc_rd_ctrl_if.master bus
);

    localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic             pop;

    // Address bit 30 and the sub-word byte offset are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_in[30], bus.addr_in[2:0]};

    // Strobes are decoded from state and gated by rst so reset wins at once.
    assign bus.cmd_en    = !rst && (state == ST_CMD) && !bus.cmd_full;
    assign pop           = !rst && (state == ST_READ) && !bus.rd_empty;
    assign bus.rd_en     = pop;
    assign bus.mc_rd_rdy = !rst && (state == ST_ADVANCE);
    assign busy          = !rst && (state != ST_IDLE);
    assign bus.cmd_instr = MIG_CMD_READ;
    assign bus.cmd_bl    = 6'(BURST_LEN - 1);

`ifdef MC_RD_TIMEOUT_EN
    logic wdt_expired;
    logic retry;

    mc_rd_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_WAIT_DATA),
        .cnt_en  (state == ST_WAIT_DATA),
        .expired (wdt_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            word_cnt          <= '0;
            bus.cmd_byte_addr <= '0;
            bus.data_out      <= '0;
            bus.data_valid    <= 1'b0;
`ifdef MC_RD_TIMEOUT_EN
            rd_timeout        <= 1'b0;
            retry             <= 1'b0;
`endif
        end else begin
            // Read-data capture: one registered word per FIFO pop.
            bus.data_valid <= pop;
            if (pop) begin
                bus.data_out <= bus.rd_data;
            end

            case (state)
                ST_IDLE: begin
                    if (run && calib_done) begin
                        state <= ST_CMD;
`ifdef MC_RD_TIMEOUT_EN
                        // After a timeout keep the old address for the retry.
                        if (!retry) begin
                            bus.cmd_byte_addr <= {bus.addr_in[29:3], 3'b000};
                        end
                        retry <= 1'b0;
`else
                        bus.cmd_byte_addr <= {bus.addr_in[29:3], 3'b000};
`endif
                    end
                end
                ST_CMD: begin
                    if (!bus.cmd_full) begin
                        state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (!bus.rd_empty) begin
                        state <= ST_READ;
`ifdef MC_RD_TIMEOUT_EN
                    end else if (wdt_expired) begin
                        rd_timeout <= 1'b1;
                        retry      <= 1'b1;
                        state      <= ST_IDLE;
`endif
                    end
                end
                ST_READ: begin
                    if (pop) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= ST_ADVANCE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ST_ADVANCE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_rd_ctrl.sv
// tb_mc_rd_ctrl: directed self-checking bench for mc_rd_ctrl (BURST_LEN=2,
// TIMEOUT_CYCLES=16). Inputs change 1 ns after posedge, outputs are checked
// 3 ns after posedge; a negedge monitor counts strobes and collects words.
module tb_mc_rd_ctrl;
    import mc_rd_pkg::*;

    logic clk = 1'b0;
    logic rst, run, calib_done, busy, rd_timeout;

    always #5 clk = ~clk;

    mc_rd_ctrl_if bus();

    mc_rd_ctrl #(
        .BURST_LEN      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .calib_done (calib_done),
        .busy       (busy),
        .rd_timeout (rd_timeout),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;

    int cmd_cnt = 0, rdy_cnt = 0, cmd_run = 0, cmd_run_max = 0;
    logic [31:0] words[$];
    logic [29:0] cmd_addrs[$];

    always @(negedge clk) begin
        if (bus.cmd_en === 1'b1) begin
            cmd_cnt <= cmd_cnt + 1;
            cmd_run <= cmd_run + 1;
            if (cmd_run + 1 > cmd_run_max) cmd_run_max <= cmd_run + 1;
            cmd_addrs.push_back(bus.cmd_byte_addr);
        end else begin
            cmd_run <= 0;
        end
        if (bus.mc_rd_rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;
        if (bus.data_valid === 1'b1) words.push_back(bus.data_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            run          = 1'($urandom_range(0, 1));
            calib_done   = 1'($urandom_range(0, 1));
            bus.addr_in  = 31'($urandom);
            bus.cmd_full = 1'($urandom_range(0, 1));
            bus.rd_data  = $urandom;
            bus.rd_empty = 1'($urandom_range(0, 1));
            #2;
            total++;
            if ({bus.cmd_en, bus.rd_en, bus.mc_rd_rdy, bus.data_valid, busy, rd_timeout} !== 6'b0) begin
                bad++;
                $display("FAIL reset_ctrl cyc=%0d got=%b want=000000", i,
                         {bus.cmd_en, bus.rd_en, bus.mc_rd_rdy, bus.data_valid, busy, rd_timeout});
            end
            total++;
            if (bus.cmd_byte_addr !== 30'h0) begin
                bad++; $display("FAIL reset_addr got=%h want=0", bus.cmd_byte_addr);
            end
            total++;
            if (bus.data_out !== 32'h0) begin
                bad++; $display("FAIL reset_data got=%h want=0", bus.data_out);
            end
            step();
        end
        total++;
        if (bus.cmd_bl !== 6'd1) begin
            bad++; $display("FAIL cmd_bl got=%0d want=1", bus.cmd_bl);
        end
        total++;
        if (bus.cmd_instr !== 3'b001) begin
            bad++; $display("FAIL cmd_instr got=%b want=001", bus.cmd_instr);
        end
        rst = 1'b0; run = 1'b0; calib_done = 1'b0; bus.addr_in = '0;
        bus.cmd_full = 1'b0; bus.rd_empty = 1'b1; bus.rd_data = '0;
        step();
    endtask

    task automatic test_basic();
        int c0, r0, w0;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size();
        calib_done = 1'b1; run = 1'b1; bus.addr_in = 31'h0000_20C0;
        step();                                   // CMD
        run = 1'b0; #2;
        total++;
        if (bus.cmd_en !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_cmd got=%b%b want=11", bus.cmd_en, busy);
        end
        total++;
        if (bus.cmd_byte_addr !== 30'h20C0) begin
            bad++; $display("FAIL basic_addr got=%h want=20c0", bus.cmd_byte_addr);
        end
        step();                                   // WAIT_DATA
        bus.rd_empty = 1'b0; bus.rd_data = 32'hDEAD0001; #2;
        total++;
        if (bus.cmd_en !== 1'b0 || bus.rd_en !== 1'b0) begin
            bad++; $display("FAIL basic_wait got=%b%b want=00", bus.cmd_en, bus.rd_en);
        end
        step();                                   // READ, word 1
        #2;
        total++;
        if (bus.rd_en !== 1'b1 || bus.data_valid !== 1'b0) begin
            bad++; $display("FAIL basic_read1 got=%b%b want=10", bus.rd_en, bus.data_valid);
        end
        step();                                   // READ, word 2
        bus.rd_data = 32'hDEAD0002; #2;
        total++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 32'hDEAD0001) begin
            bad++; $display("FAIL basic_word1 got=%b/%h want=1/dead0001", bus.data_valid, bus.data_out);
        end
        step();                                   // ADVANCE
        bus.rd_empty = 1'b1; #2;
        total++;
        if (bus.mc_rd_rdy !== 1'b1 || bus.data_out !== 32'hDEAD0002) begin
            bad++; $display("FAIL basic_adv got=%b/%h want=1/dead0002", bus.mc_rd_rdy, bus.data_out);
        end
        step();                                   // IDLE
        #2;
        total++;
        if (bus.mc_rd_rdy !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_idle got=%b%b want=00", bus.mc_rd_rdy, busy);
        end
        total++;
        if (cmd_cnt - c0 != 1 || rdy_cnt - r0 != 1 || words.size() - w0 != 2) begin
            bad++; $display("FAIL basic_counts got=%0d/%0d/%0d want=1/1/2", cmd_cnt - c0, rdy_cnt - r0, words.size() - w0);
        end else begin
            total++;
            if (words[w0] !== 32'hDEAD0001 || words[w0+1] !== 32'hDEAD0002) begin
                bad++; $display("FAIL basic_order got=%h,%h want=dead0001,dead0002", words[w0], words[w0+1]);
            end
        end
    endtask

    task automatic test_cmd_full();
        int c0, r0, w0;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size();
        bus.addr_in = 31'h0000_0440; bus.cmd_full = 1'b1; run = 1'b1;
        step();                                   // CMD
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            total++;
            if (bus.cmd_en !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL full_hold cyc=%0d got=%b%b want=01", i, bus.cmd_en, busy);
            end
            step();
        end
        bus.cmd_full = 1'b0; #2;
        total++;
        if (bus.cmd_en !== 1'b1 || bus.cmd_byte_addr !== 30'h440) begin
            bad++; $display("FAIL full_release got=%b/%h want=1/440", bus.cmd_en, bus.cmd_byte_addr);
        end
        step();                                   // WAIT_DATA
        bus.rd_empty = 1'b0; bus.rd_data = 32'hA5A5_0001; #2;
        total++;
        if (bus.cmd_en !== 1'b0) begin
            bad++; $display("FAIL full_single got=%b want=0", bus.cmd_en);
        end
        step();                                   // READ word 1
        step();                                   // READ word 2
        bus.rd_data = 32'hA5A5_0002;
        step();                                   // ADVANCE
        bus.rd_empty = 1'b1;
        step();                                   // IDLE
        #2;
        total++;
        if (cmd_cnt - c0 != 1 || rdy_cnt - r0 != 1 || words.size() - w0 != 2) begin
            bad++; $display("FAIL full_counts got=%0d/%0d/%0d want=1/1/2", cmd_cnt - c0, rdy_cnt - r0, words.size() - w0);
        end else begin
            total++;
            if (words[w0] !== 32'hA5A5_0001 || words[w0+1] !== 32'hA5A5_0002) begin
                bad++; $display("FAIL full_order got=%h,%h want=a5a50001,a5a50002", words[w0], words[w0+1]);
            end
        end
    endtask

    task automatic test_empty_gaps();
        int c0, r0, w0, k;
        bit [4:0] gap;
        logic exp_dv;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size();
        gap = 5'b01101;                           // per READ cycle: 1,0,1,1,0
        bus.addr_in = 31'h0000_0800; run = 1'b1;
        step();                                   // CMD
        run = 1'b0;
        step();                                   // WAIT_DATA
        bus.rd_empty = 1'b0; bus.rd_data = 32'h1111_0001;
        step();                                   // READ
        k = 0;
        for (int i = 0; i < 5; i++) begin
            bus.rd_empty = gap[i];
            bus.rd_data  = (k == 0) ? 32'h1111_0001 : 32'h1111_0002;
            #2;
            exp_dv = (i > 0) && (gap[i-1] == 1'b0);
            total++;
            if (bus.rd_en !== ~gap[i]) begin
                bad++; $display("FAIL gap_rd_en cyc=%0d got=%b want=%b", i, bus.rd_en, ~gap[i]);
            end
            total++;
            if (bus.data_valid !== exp_dv) begin
                bad++; $display("FAIL gap_dv cyc=%0d got=%b want=%b", i, bus.data_valid, exp_dv);
            end
            if (gap[i] == 1'b0) k++;
            step();
        end
        bus.rd_empty = 1'b1; #2;
        total++;
        if (bus.mc_rd_rdy !== 1'b1 || bus.data_out !== 32'h1111_0002) begin
            bad++; $display("FAIL gap_adv got=%b/%h want=1/11110002", bus.mc_rd_rdy, bus.data_out);
        end
        step();
        #2;
        total++;
        if (words.size() - w0 != 2 || rdy_cnt - r0 != 1 || cmd_cnt - c0 != 1) begin
            bad++; $display("FAIL gap_counts got=%0d/%0d/%0d want=2/1/1", words.size() - w0, rdy_cnt - r0, cmd_cnt - c0);
        end else begin
            total++;
            if (words[w0] !== 32'h1111_0001 || words[w0+1] !== 32'h1111_0002) begin
                bad++; $display("FAIL gap_order got=%h,%h want=11110001,11110002", words[w0], words[w0+1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, r0, w0, a0, nxt, ncmd;
        logic popped;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size(); a0 = cmd_addrs.size();
        nxt = 0; ncmd = 0; popped = 1'b0;
        bus.rd_empty = 1'b0; bus.rd_data = 32'hB0B0_0000;
        bus.addr_in = 31'h7FFF_FFFF; run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (popped) begin
                nxt++;
                bus.rd_data = 32'hB0B0_0000 + 32'(nxt);
            end
            #2;
            popped = bus.rd_en;
            if (bus.cmd_en === 1'b1) ncmd++;
            if (ncmd == 2) run = 1'b0;
            if (bus.mc_rd_rdy === 1'b1) bus.addr_in = 31'h0000_0105;
            if (i == 4 || i == 10) begin
                total++;
                if (bus.mc_rd_rdy !== 1'b1) begin
                    bad++; $display("FAIL b2b_latency cyc=%0d got=%b want=1", i, bus.mc_rd_rdy);
                end
            end
            if (i == 5) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL b2b_idle_gap got=%b want=0", busy);
                end
            end
        end
        bus.rd_empty = 1'b1;
        total++;
        if (cmd_cnt - c0 != 2 || rdy_cnt - r0 != 2 || words.size() - w0 != 4) begin
            bad++; $display("FAIL b2b_counts got=%0d/%0d/%0d want=2/2/4", cmd_cnt - c0, rdy_cnt - r0, words.size() - w0);
        end else begin
            total++;
            if (cmd_addrs[a0] !== 30'h3FFF_FFF8 || cmd_addrs[a0+1] !== 30'h0000_0100) begin
                bad++; $display("FAIL b2b_addr got=%h,%h want=3ffffff8,00000100", cmd_addrs[a0], cmd_addrs[a0+1]);
            end
            for (int j = 0; j < 4; j++) begin
                total++;
                if (words[w0+j] !== 32'hB0B0_0000 + 32'(j)) begin
                    bad++; $display("FAIL b2b_word%0d got=%h want=%h", j, words[w0+j], 32'hB0B0_0000 + 32'(j));
                end
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL b2b_end_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_timeout();
        int c0, r0, w0, a0;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size(); a0 = cmd_addrs.size();
        bus.addr_in = 31'h4000_123F; bus.rd_empty = 1'b1; run = 1'b1;
        step();                                   // CMD
`ifdef MC_RD_TIMEOUT_EN
        #2;
        total++;
        if (bus.cmd_en !== 1'b1 || bus.cmd_byte_addr !== 30'h1238) begin
            bad++; $display("FAIL tmo_cmd got=%b/%h want=1/1238", bus.cmd_en, bus.cmd_byte_addr);
        end
        step();                                   // WAIT_DATA cycle 1
        for (int i = 0; i < 16; i++) begin
            #2;
            total++;
            if (rd_timeout !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL tmo_wait cyc=%0d got=%b%b want=01", i, rd_timeout, busy);
            end
            step();
        end
        #2;
        total++;
        if (rd_timeout !== 1'b1 || busy !== 1'b0 || bus.mc_rd_rdy !== 1'b0) begin
            bad++; $display("FAIL tmo_fire got=%b%b%b want=100", rd_timeout, busy, bus.mc_rd_rdy);
        end
        step();                                   // retry CMD
        run = 1'b0; #2;
        total++;
        if (bus.cmd_en !== 1'b1 || bus.cmd_byte_addr !== 30'h1238 || rd_timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_retry got=%b/%h/%b want=1/1238/1", bus.cmd_en, bus.cmd_byte_addr, rd_timeout);
        end
        step();                                   // WAIT_DATA
        bus.rd_empty = 1'b0; bus.rd_data = 32'hC0DE_0001;
        step();                                   // READ word 1
        step();                                   // READ word 2
        bus.rd_data = 32'hC0DE_0002;
        step();                                   // ADVANCE
        bus.rd_empty = 1'b1;
        step();
        #2;
        total++;
        if (cmd_cnt - c0 != 2 || rdy_cnt - r0 != 1 || words.size() - w0 != 2) begin
            bad++; $display("FAIL tmo_counts got=%0d/%0d/%0d want=2/1/2", cmd_cnt - c0, rdy_cnt - r0, words.size() - w0);
        end else begin
            total++;
            if (cmd_addrs[a0+1] !== 30'h1238 || words[w0+1] !== 32'hC0DE_0002) begin
                bad++; $display("FAIL tmo_data got=%h/%h want=1238/c0de0002", cmd_addrs[a0+1], words[w0+1]);
            end
        end
`else
        run = 1'b0;
        step();                                   // WAIT_DATA
        for (int i = 0; i < 40; i++) begin
            #2;
            total++;
            if (rd_timeout !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL nowdt_wait cyc=%0d got=%b%b want=01", i, rd_timeout, busy);
            end
            step();
        end
        bus.rd_empty = 1'b0; bus.rd_data = 32'hC0DE_0001;
        step();                                   // READ word 1
        step();                                   // READ word 2
        bus.rd_data = 32'hC0DE_0002;
        step();                                   // ADVANCE
        bus.rd_empty = 1'b1;
        step();
        #2;
        total++;
        if (cmd_cnt - c0 != 1 || rdy_cnt - r0 != 1 || words.size() - w0 != 2) begin
            bad++; $display("FAIL nowdt_counts got=%0d/%0d/%0d want=1/1/2", cmd_cnt - c0, rdy_cnt - r0, words.size() - w0);
        end else begin
            total++;
            if (cmd_addrs[a0] !== 30'h1238 || words[w0+1] !== 32'hC0DE_0002) begin
                bad++; $display("FAIL nowdt_data got=%h/%h want=1238/c0de0002", cmd_addrs[a0], words[w0+1]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c0, r0, w0;
        c0 = cmd_cnt; r0 = rdy_cnt; w0 = words.size();
        bus.addr_in = 31'h0000_0300; bus.rd_empty = 1'b0;
        bus.rd_data = 32'hE000_0001; run = 1'b1;
        step();                                   // CMD
        run = 1'b0;
        step();                                   // WAIT_DATA
        step();                                   // READ cycle 1 (pop)
        step();                                   // READ cycle 2
        bus.rd_data = 32'hE000_0002; rst = 1'b1; #2;
        total++;
        if (bus.rd_en !== 1'b0 || bus.mc_rd_rdy !== 1'b0) begin
            bad++; $display("FAIL rstmid_gate got=%b%b want=00", bus.rd_en, bus.mc_rd_rdy);
        end
        step();
        rst = 1'b0; bus.rd_empty = 1'b1; #2;
        total++;
        if (busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 32'h0 || rd_timeout !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle got=%b%b/%h/%b want=00/0/0", busy, bus.data_valid, bus.data_out, rd_timeout);
        end
        for (int i = 0; i < 4; i++) step();
        #2;
        total++;
        if (rdy_cnt - r0 != 0 || words.size() - w0 != 1 || cmd_cnt - c0 != 1) begin
            bad++; $display("FAIL rstmid_counts got=%0d/%0d/%0d want=0/1/1", rdy_cnt - r0, words.size() - w0, cmd_cnt - c0);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; calib_done = 1'b0;
        bus.addr_in = '0; bus.cmd_full = 1'b0; bus.rd_data = '0; bus.rd_empty = 1'b1;
        test_reset();
        test_basic();
        test_cmd_full();
        test_empty_gaps();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        total++;
        if (cmd_run_max > 1) begin
            bad++; $display("FAIL cmd_en_run got=%0d want<=1", cmd_run_max);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
